// File: rtl/rotl_pipe.sv
// rtl/rotl_pipe.sv - 8-bit left-rotate barrel shifter, three-stage valid/ready pipeline.
module rotl_pipe (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic [2:0] i_shift_amt,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_shift_data,
  output logic       o_busy
);

  logic       r_s1_valid, r_s2_valid, r_s3_valid;
  logic [7:0] r_s1_data, r_s2_data, r_s3_data;
  logic [1:0] r_s1_amt;
  logic       r_s2_amt;

  logic       w_s1_load, w_s2_load, w_s3_load;
  logic       w_in_fire;
  logic [7:0] w_s1_rot, w_s2_rot, w_s3_rot;

  // A stage loads when empty or when its current entry moves on this cycle.
  assign w_s3_load = !r_s3_valid || i_ready;
  assign w_s2_load = !r_s2_valid || w_s3_load;
  assign w_s1_load = !r_s1_valid || w_s2_load;

  assign o_ready   = i_rst_n && w_s1_load;
  assign w_in_fire = i_valid && o_ready;

  assign w_s1_rot = i_shift_amt[0] ? {i_data[6:0], i_data[7]}       : i_data;
  assign w_s2_rot = r_s1_amt[0]    ? {r_s1_data[5:0], r_s1_data[7:6]} : r_s1_data;
  assign w_s3_rot = r_s2_amt       ? {r_s2_data[3:0], r_s2_data[7:4]} : r_s2_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1_data  <= 8'h00;
      r_s2_data  <= 8'h00;
      r_s3_data  <= 8'h00;
      r_s1_amt   <= 2'b00;
      r_s2_amt   <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= w_in_fire;
      end
      // Data registers only move with a real entry, so idle inputs never disturb them.
      if (w_s1_load && w_in_fire) begin
        r_s1_data <= w_s1_rot;
        r_s1_amt  <= i_shift_amt[2:1];
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load && r_s1_valid) begin
        r_s2_data <= w_s2_rot;
        r_s2_amt  <= r_s1_amt[1];
      end
      if (w_s3_load) begin
        r_s3_valid <= r_s2_valid;
      end
      if (w_s3_load && r_s2_valid) begin
        r_s3_data <= w_s3_rot;
      end
    end
  end

  assign o_valid      = r_s3_valid;
  assign o_shift_data = r_s3_data;
  assign o_busy       = r_s1_valid || r_s2_valid || r_s3_valid;

endmodule

// File: tb/tb_rotl_pipe.sv
// tb/tb_rotl_pipe.sv - scoreboard bench for rotl_pipe.
module tb_rotl_pipe;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic [2:0] i_shift_amt;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_shift_data;
  logic       o_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int out_cnt   = 0;
  int stall_cnt = 0;
  logic [7:0] exp_q[$];

  rotl_pipe dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_shift_amt(i_shift_amt), .o_valid(o_valid),
    .i_ready(i_ready), .o_shift_data(o_shift_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] rotl_model(input logic [7:0] d, input int n);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] rotr_model(input logic [7:0] d, input int n);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  // Output side of the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      logic [7:0] e;
      out_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected: got %02h, required no output", o_shift_data);
      end else begin
        e = exp_q.pop_front();
        if (o_shift_data !== e)
          $display("FAIL scoreboard_data: got %02h, required %02h", o_shift_data, e);
        else
          pass_cnt++;
      end
    end
  end

  // Present one request and hold it until accepted; the expected result is queued on acceptance.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [7:0] e);
    bit done = 0;
    i_valid     = 1'b1;
    i_data      = d;
    i_shift_amt = a;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge i_clk);
      if (o_ready) begin
        exp_q.push_back(e);
        done = 1;
      end else begin
        stall_cnt++;
      end
      @(posedge i_clk); #1;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL send_timeout: request %02h/%0d never accepted", d, a);
    end
  endtask

  task automatic drain();
    int c = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge i_clk); #1;
      c++;
    end
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    else
      pass_cnt++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = 8'hFF; i_shift_amt = 3'd5;
    @(posedge i_clk); @(posedge i_clk); #1;
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL reset_ready_low: got %b, required 0", o_ready); else pass_cnt++;
    total_cnt++;
    if ({o_valid, o_busy, o_shift_data} !== 10'h000)
      $display("FAIL reset_state: valid=%b busy=%b data=%02h, required 0 0 00", o_valid, o_busy, o_shift_data);
    else pass_cnt++;
    i_rst_n = 1'b1;
    #1;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready_high: got %b, required 1", o_ready); else pass_cnt++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_single();
    i_ready = 1'b1;
    send(8'hB4, 3'd3, 8'hA5);
    i_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      total_cnt++;
      if (o_valid !== (k == 3))
        $display("FAIL single_valid_edge%0d: got %b, required %b", k, o_valid, (k == 3));
      else pass_cnt++;
      if (k == 3) begin
        total_cnt++;
        if (o_shift_data !== 8'hA5) $display("FAIL single_data: got %02h, required a5", o_shift_data);
        else pass_cnt++;
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_amt_edges();
    i_ready = 1'b1;
    send(8'h01, 3'd0, 8'h01);
    send(8'h01, 3'd7, 8'h80);
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_exhaustive();
    int base = out_cnt;
    stall_cnt = 0;
    i_ready = 1'b1;
    for (int a = 0; a < 8; a++)
      for (int d = 0; d < 256; d++)
        send(d[7:0], a[2:0], rotl_model(d[7:0], a));
    i_valid = 1'b0;
    total_cnt++;
    if (stall_cnt != 0) $display("FAIL sweep_throughput: %0d stall cycles, required 0", stall_cnt);
    else pass_cnt++;
    drain();
    total_cnt++;
    if (out_cnt - base != 2048) $display("FAIL sweep_count: got %0d results, required 2048", out_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int idx = 0;
    logic [7:0] held;
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1; i_data = d[idx]; i_shift_amt = 3'(idx + 1);
      @(negedge i_clk);
      if (o_ready) begin
        exp_q.push_back(rotl_model(d[idx], idx + 1));
        idx++;
      end
      @(posedge i_clk); #1;
    end
    total_cnt++;
    if (idx != 3) $display("FAIL bp_accepted: got %0d, required 3", idx); else pass_cnt++;
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b, required 0", o_ready); else pass_cnt++;
    held = o_shift_data;
    @(posedge i_clk); @(posedge i_clk); #1;
    total_cnt++;
    if (o_shift_data !== held || o_valid !== 1'b1)
      $display("FAIL bp_hold: data=%02h valid=%b, required %02h 1", o_shift_data, o_valid, held);
    else pass_cnt++;
    i_ready = 1'b1;
    #1;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL bp_full_passthrough_ready: got %b, required 1", o_ready); else pass_cnt++;
    while (idx < 5) begin
      send(d[idx], 3'(idx + 1), rotl_model(d[idx], idx + 1));
      idx++;
    end
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_inverse();
    i_ready = 1'b1;
    for (int n = 0; n < 8; n++)
      send(rotr_model(8'h81, n), n[2:0], 8'h81);
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    i_ready = 1'b0;
    send(8'h5A, 3'd1, 8'hB4);
    send(8'hC3, 3'd2, 8'h0F);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    exp_q.delete();
    @(posedge i_clk); #1;
    total_cnt++;
    if ({o_valid, o_busy, o_shift_data} !== 10'h000)
      $display("FAIL midreset_state: valid=%b busy=%b data=%02h, required 0 0 00", o_valid, o_busy, o_shift_data);
    else pass_cnt++;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_valid || o_busy) seen = 1;
    end
    total_cnt++;
    if (seen) $display("FAIL midreset_stale: stale entry observed, required none");
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_amt_edges();
    test_exhaustive();
    test_backpressure();
    test_inverse();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
